// File: rtl/alu_ctrl_if.sv
// Decoder command channel and memory-write response channel of the ALU sequencer.
// The master drives commands and accepts responses; the slave is the sequencer.
interface alu_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op;
    logic [1:0] cmd_src1;
    logic [1:0] cmd_src2;
    logic [7:0] cmd_imm;
    logic [1:0] cmd_dst;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_imm, cmd_dst, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_imm, cmd_dst, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_ctrl.sv
// ALU sequencer: owns A/X/Y/P, issues one micro-op at a time to an external ALU,
// writes the result back to a register or hands it to the memory path.
module alu_ctrl #(
    parameter logic [7:0] P_RESET = 8'h24,
    parameter logic [7:0] OP_MAX  = 8'h18
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.slave  bus,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    output logic [7:0] alu_sel,
    output logic [7:0] alu_status,
    input  logic [7:0] alu_out,
    input  logic [7:0] alu_next_status,
    input  logic       p_wr_en,
    input  logic [7:0] p_wr_data,
    output logic [7:0] reg_a,
    output logic [7:0] reg_x,
    output logic [7:0] reg_y,
    output logic [7:0] reg_p,
    output logic       illegal_op
);
    localparam logic [7:0] P_BIT5  = 8'h20;
    localparam logic [1:0] DST_A   = 2'd0;
    localparam logic [1:0] DST_X   = 2'd1;
    localparam logic [1:0] DST_Y   = 2'd2;
    localparam logic [1:0] DST_MEM = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, WB, RSP} state_t;

    state_t     state;
    logic [1:0] dst_q;
    logic [7:0] res_q;
    logic [7:0] status_q;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       cmd_ready;
    logic [7:0] in1_mux;
    logic [7:0] in2_mux;

    function automatic logic op_legal(input logic [7:0] op);
        return (op != 8'h00) && (op <= OP_MAX);
    endfunction

    // CMP, the flag ops and BIT only update P; everything else legal carries data.
    function automatic logic op_writes_data(input logic [7:0] op);
        return (op == 8'h01) || (op == 8'h02) || ((op >= 8'h04) && (op <= 8'h0F));
    endfunction

    function automatic logic [7:0] operand(input logic [1:0] src, input logic [7:0] a,
                                           input logic [7:0] x, input logic [7:0] y,
                                           input logic [7:0] imm);
        logic [7:0] v;
        case (src)
            2'd0:    v = a;
            2'd1:    v = x;
            2'd2:    v = y;
            default: v = imm;
        endcase
        return v;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        in1_mux = operand(bus.cmd_src1, reg_a, reg_x, reg_y, bus.cmd_imm);
        in2_mux = operand(bus.cmd_src2, reg_a, reg_x, reg_y, bus.cmd_imm);
    end

    // Gated by rst_n so the decoder never sees ready while reset is held.
    assign cmd_ready     = rst_n && (state == IDLE);
    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign alu_status    = reg_p;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            reg_a      <= 8'h00;
            reg_x      <= 8'h00;
            reg_y      <= 8'h00;
            reg_p      <= P_RESET | P_BIT5;
            alu_in1    <= 8'h00;
            alu_in2    <= 8'h00;
            alu_sel    <= 8'h00;
            dst_q      <= DST_A;
            res_q      <= 8'h00;
            status_q   <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (p_wr_en) begin
                        reg_p <= p_wr_data | P_BIT5;
                    end
                    if (bus.cmd_valid && cmd_ready) begin
                        if (op_legal(bus.cmd_op)) begin
                            alu_in1 <= in1_mux;
                            alu_in2 <= in2_mux;
                            alu_sel <= bus.cmd_op;
                            dst_q   <= bus.cmd_dst;
                            state   <= EXEC;
                        end else begin
                            illegal_op <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    res_q    <= alu_out;
                    status_q <= alu_next_status;
                    state    <= WB;
                end
                WB: begin
                    reg_p <= status_q | P_BIT5;
                    state <= IDLE;
                    if (op_writes_data(alu_sel)) begin
                        case (dst_q)
                            DST_A: reg_a <= res_q;
                            DST_X: reg_x <= res_q;
                            DST_Y: reg_y <= res_q;
                            DST_MEM: begin
                                rsp_data  <= res_q;
                                rsp_valid <= 1'b1;
                                state     <= RSP;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                RSP: begin
                    if (p_wr_en) begin
                        reg_p <= p_wr_data | P_BIT5;
                    end
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed plan steps followed by random commands,
// all checked against an architectural register model and a behavioural ALU.
module tb_alu_ctrl;
    localparam logic [1:0] S_A = 2'd0, S_X = 2'd1, S_Y = 2'd2, S_IMM = 2'd3;
    localparam logic [1:0] D_A = 2'd0, D_X = 2'd1, D_Y = 2'd2, D_MEM = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_in1, alu_in2, alu_sel, alu_status;
    logic [7:0] alu_out, alu_next_status;
    logic       p_wr_en;
    logic [7:0] p_wr_data;
    logic [7:0] reg_a, reg_x, reg_y, reg_p;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_a, m_x, m_y, m_p;

    always #5 clk = ~clk;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_status(alu_status),
        .alu_out(alu_out), .alu_next_status(alu_next_status),
        .p_wr_en(p_wr_en), .p_wr_data(p_wr_data),
        .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .reg_p(reg_p),
        .illegal_op(illegal_op)
    );

    // 6502-style ALU stand-in: {result, next_status}. P bits: N7 V6 Z1 C0.
    function automatic logic [15:0] alu_model(input logic [7:0] op, input logic [7:0] in1,
                                              input logic [7:0] in2, input logic [7:0] p);
        logic [8:0] t;
        logic [7:0] r;
        logic [7:0] s;
        s = p;
        t = 9'h000;
        case (op)
            8'h03: begin r = in1 - in2; s[0] = (in1 >= in2); end
            8'h06: begin
                t = {1'b0, in1} + {1'b0, in2} + {8'h00, p[0]};
                r = t[7:0];
                s[0] = t[8];
                s[6] = (in1[7] == in2[7]) && (r[7] != in1[7]);
            end
            8'h0B: begin r = {in1[6:0], 1'b0}; s[0] = in1[7]; end
            8'h0F: r = in2;
            default: r = in1 ^ in2 ^ op;
        endcase
        if (op >= 8'h10 && op <= 8'h17) begin
            s = p ^ (8'h01 << op[2:0]);
        end else if (op == 8'h18) begin
            r = in1 & in2;
            s[7] = in2[7];
            s[6] = in2[6];
            s[1] = (r == 8'h00);
        end else begin
            s[7] = r[7];
            s[1] = (r == 8'h00);
        end
        return {r, s};
    endfunction

    always_comb {alu_out, alu_next_status} = alu_model(alu_sel, alu_in1, alu_in2, alu_status);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_a"}, reg_a, m_a);
        check({tag, "_x"}, reg_x, m_x);
        check({tag, "_y"}, reg_y, m_y);
        check({tag, "_p"}, reg_p, m_p);
    endtask

    task automatic model_reset();
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = 8'h24;
    endtask

    function automatic logic [7:0] pick(input logic [1:0] src, input logic [7:0] imm);
        case (src)
            S_A:     return m_a;
            S_X:     return m_x;
            S_Y:     return m_y;
            default: return imm;
        endcase
    endfunction

    task automatic drive_cmd(input logic [7:0] op, input logic [1:0] s1, input logic [1:0] s2,
                             input logic [7:0] imm, input logic [1:0] dst);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src1  = s1;
        bus.cmd_src2  = s2;
        bus.cmd_imm   = imm;
        bus.cmd_dst   = dst;
    endtask

    // Starts and ends at a negedge with the DUT idle. pw_phase: 0 none, 1 at accept,
    // 2 during EXEC+WB (must be ignored), 3 while the response is pending.
    task automatic run_cmd(input logic [7:0] op, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [7:0] imm, input logic [1:0] dst, input int stall,
                           input int pw_phase, input logic [7:0] pwd);
        logic [15:0] r;
        logic [7:0]  in1, in2, res;
        bit          legal, status_only;
        legal       = (op != 8'h00) && (op <= 8'h18);
        status_only = (op == 8'h03) || (op >= 8'h10);
        check("idle_ready", bus.cmd_ready, 8'h01);
        drive_cmd(op, s1, s2, imm, dst);
        p_wr_data = pwd;
        p_wr_en   = (pw_phase == 1);
        in1 = pick(s1, imm);
        in2 = pick(s2, imm);
        if (pw_phase == 1) m_p = pwd | 8'h20;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (!legal) begin
            p_wr_en = 1'b0;
            check("illegal_pulse", illegal_op, 8'h01);
            check("illegal_ready", bus.cmd_ready, 8'h01);
            check_regs("illegal");
            return;
        end
        p_wr_en = (pw_phase == 2);
        r = alu_model(op, in1, in2, m_p);
        res = r[15:8];
        check("exec_ready", bus.cmd_ready, 8'h00);
        check("exec_illegal", illegal_op, 8'h00);
        check("exec_sel", alu_sel, op);
        check("exec_in1", alu_in1, in1);
        check("exec_in2", alu_in2, in2);
        @(negedge clk);
        check("wb_ready", bus.cmd_ready, 8'h00);
        check("wb_rsp", bus.rsp_valid, 8'h00);
        @(negedge clk);
        p_wr_en = 1'b0;
        m_p = r[7:0] | 8'h20;
        if (!status_only) begin
            case (dst)
                D_A: m_a = res;
                D_X: m_x = res;
                D_Y: m_y = res;
                default: ;
            endcase
        end
        check_regs("wb");
        if (!status_only && dst == D_MEM) begin
            check("rsp_busy_ready", bus.cmd_ready, 8'h00);
            if (pw_phase == 3) p_wr_en = 1'b1;
            for (int i = 0; i < stall; i++) begin
                check("rsp_hold_valid", bus.rsp_valid, 8'h01);
                check("rsp_hold_data", bus.rsp_data, res);
                @(negedge clk);
                if (p_wr_en) begin
                    p_wr_en = 1'b0;
                    m_p = pwd | 8'h20;
                    check("rsp_p_load", reg_p, m_p);
                end
            end
            bus.rsp_ready = 1'b1;
            check("rsp_valid", bus.rsp_valid, 8'h01);
            check("rsp_data", bus.rsp_data, res);
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            if (p_wr_en) begin
                p_wr_en = 1'b0;
                m_p = pwd | 8'h20;
            end
            check("rsp_done_valid", bus.rsp_valid, 8'h00);
        end else begin
            check("no_rsp", bus.rsp_valid, 8'h00);
        end
        check("ready_back", bus.cmd_ready, 8'h01);
        check_regs("end");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 8'h00; bus.cmd_src1 = S_A; bus.cmd_src2 = S_A;
        bus.cmd_imm = 8'h00; bus.cmd_dst = D_A; bus.rsp_ready = 1'b0;
        p_wr_en = 1'b0; p_wr_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);

        // 1. reset state and release
        check("rst_ready", bus.cmd_ready, 8'h00);
        check_regs("rst");
        check("rst_rsp_valid", bus.rsp_valid, 8'h00);
        check("rst_rsp_data", bus.rsp_data, 8'h00);
        check("rst_illegal", illegal_op, 8'h00);
        check("rst_sel", alu_sel, 8'h00);
        check("rst_in1", alu_in1, 8'h00);
        check("rst_in2", alu_in2, 8'h00);
        check("rst_status", alu_status, 8'h24);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", bus.cmd_ready, 8'h01);
        check("rel_p", reg_p, 8'h24);

        // 2. load A then ADC into A
        run_cmd(8'h0F, S_A, S_IMM, 8'h50, D_A, 0, 0, 8'h00);
        check("t2_load_a", reg_a, 8'h50);
        run_cmd(8'h06, S_A, S_IMM, 8'h50, D_A, 0, 0, 8'h00);
        check("t2_adc_a", reg_a, 8'hA0);
        check("t2_adc_p", reg_p, 8'hE4);

        // 3. CMP is status-only
        run_cmd(8'h0F, S_A, S_IMM, 8'h05, D_X, 0, 0, 8'h00);
        run_cmd(8'h03, S_X, S_IMM, 8'h05, D_X, 0, 0, 8'h00);
        check("t3_x", reg_x, 8'h05);
        check("t3_zc", {6'b0, reg_p[1:0]}, 8'h03);

        // 4. memory destination with 5 cycles of backpressure
        run_cmd(8'h0B, S_IMM, S_IMM, 8'h81, D_MEM, 5, 0, 8'h00);
        check("t4_c", {7'b0, reg_p[0]}, 8'h01);

        // 5. illegal op, then immediate accept; external P loads in each legal phase
        run_cmd(8'h00, S_A, S_A, 8'h11, D_A, 0, 0, 8'h00);
        run_cmd(8'h0F, S_A, S_IMM, 8'h3C, D_Y, 0, 0, 8'h00);
        run_cmd(8'h1F, S_A, S_A, 8'h11, D_A, 0, 0, 8'h00);
        p_wr_en = 1'b1; p_wr_data = 8'h00;
        @(negedge clk);
        p_wr_en = 1'b0;
        m_p = 8'h20;
        check("t5_p_forced", reg_p, 8'h20);
        run_cmd(8'h06, S_Y, S_IMM, 8'h01, D_A, 0, 1, 8'h01);
        check("t5_adc_carry_in", reg_a, 8'h3E);
        run_cmd(8'h15, S_A, S_A, 8'h00, D_A, 0, 2, 8'hFF);
        run_cmd(8'h0B, S_IMM, S_IMM, 8'h40, D_MEM, 2, 3, 8'hC3);

        // 6. reset during WB, then during RSP
        run_cmd(8'h0F, S_A, S_IMM, 8'h77, D_A, 0, 0, 8'h00);
        drive_cmd(8'h06, S_IMM, S_IMM, 8'h33, D_A);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_a", reg_a, 8'h00);
        check("t6_p", reg_p, 8'h24);
        check("t6_ready", bus.cmd_ready, 8'h00);
        @(negedge clk);
        check("t6_a_hold", reg_a, 8'h00);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        drive_cmd(8'h0F, S_A, S_IMM, 8'h9A, D_MEM);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rsp_pending", bus.rsp_valid, 8'h01);
        rst_n = 1'b0;
        #1;
        check("t6_rsp_dropped", bus.rsp_valid, 8'h00);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rsp_after", bus.rsp_valid, 8'h00);
        run_cmd(8'h06, S_IMM, S_IMM, 8'h12, D_X, 0, 0, 8'h00);
        check("t6_recover_x", reg_x, 8'h24);

        // random commands against the model
        for (int i = 0; i < 60; i++) begin
            run_cmd(8'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    8'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Sequencer that owns the CPU ALU and issues one micro-operation at a time from the instruction decoder. It holds the A, X, Y and P registers. It selects the ALU operands, drives alu_sel, and captures the result and next status. It then writes back to a register, or hands the result to the memory write path through a valid/ready response.

Parameters:
P_RESET, 8'h24, reset value of P (I=1, bit5=1)
OP_MAX, 8'h18, highest legal alu_sel code; 0x00 and codes above OP_MAX are illegal

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  decoder command valid
cmd_ready  out  1  controller can accept a command
cmd_op  in  8  ALU op code (alu_sel encoding 0x01..0x18)
cmd_src1  in  2  in1 source: 0=A, 1=X, 2=Y, 3=cmd_imm
cmd_src2  in  2  in2 source: 0=A, 1=X, 2=Y, 3=cmd_imm
cmd_imm  in  8  immediate or memory operand
cmd_dst  in  2  destination: 0=A, 1=X, 2=Y, 3=memory (response)
alu_in1  out  8  ALU operand 1 (registered)
alu_in2  out  8  ALU operand 2 (registered)
alu_sel  out  8  ALU op select (registered)
alu_status  out  8  status presented to ALU (equals reg_p)
alu_out  in  8  ALU result
alu_next_status  in  8  ALU computed status
rsp_valid  out  1  memory-destination result valid
rsp_ready  in  1  memory path accepts result
rsp_data  out  8  result for memory write
p_wr_en  in  1  external P load (PLP/RTI)
p_wr_data  in  8  external P value
reg_a, reg_x, reg_y, reg_p  out  8 each  architectural registers
illegal_op  out  1  one-cycle pulse on an illegal op

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - A=X=Y=0; P=P_RESET.
  - alu_in1=alu_in2=alu_sel=0.
  - rsp_valid=0, rsp_data=0, illegal_op=0.
  - cmd_ready=0 while in reset, 1 in the first cycle after release.
- Reset asserted mid-operation aborts immediately. No partial writeback; any pending rsp is dropped.
- P bit5 always reads 1, regardless of any write source.
- States: IDLE, EXEC, WB, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch the resolved in1/in2 from the current registers/imm, cmd_op into alu_sel, and cmd_dst; go to EXEC.
  - An illegal cmd_op is accepted: pulse illegal_op the next cycle, stay in IDLE, change no register.
- EXEC:
  - cmd_ready=0; the ALU evaluates combinationally.
  - On the next edge, capture alu_out and alu_next_status; go to WB.
- WB:
  - cmd_ready=0.
  - On the next edge, write P (bit5 forced) and the destination register per the op class; go to IDLE.
  - If dst=3 and the op writes data, load rsp_data and set rsp_valid; go to RSP instead.
- Op classes:
  - Data ops 0x01,0x02,0x04–0x0F: write the data destination and P.
  - Status-only ops 0x03 CMP, 0x10–0x17 flag ops, 0x18 BIT: write P only; dst is ignored and there is no response.
- RSP:
  - Hold rsp_valid and rsp_data stable until rsp_ready=1.
  - Handshake completes on rsp_valid&rsp_ready; rsp_valid clears at that edge; go to IDLE.
  - P is already updated before RSP.
- Timing:
  - Accept at edge N; registers and P updated at edge N+2; cmd_ready high in the cycle after N+2.
  - Throughput: one register-destination command per 3 cycles. Memory destinations add 1 cycle per rsp_ready wait.
- p_wr_en:
  - Honoured only in IDLE and RSP; ignored in EXEC and WB.
  - In IDLE with a simultaneous command accept, P loads p_wr_data and the latched command sees that new P in EXEC.
- Operand hazards: operands are sampled at accept. A register written by command k is visible to command k+1, because k+1 cannot be accepted before WB of k completes.

Test Plan:
1. Reset release, no commands -> A=X=Y=0, P=0x24, cmd_ready=1 on the first cycle after rst_n rises, rsp_valid=0.
2. Data op to A: set A=0x50 via op 0x0F SRC2 imm 0x50 dst A, then ADC (0x06) src1=A src2=imm 0x50 dst A with C=0 -> A=0xA0, N=1, V=1, C=0 at accept+2 edges; cmd_ready low for exactly 2 cycles.
3. Status-only op: CMP (0x03) with X=0x05, imm 0x05, dst=X -> X unchanged, Z=1, C=1; rsp_valid never asserts.
4. Memory destination with backpressure: ASL (0x0B) imm 0x81, dst=3, rsp_ready held 0 for 5 cycles -> rsp_data=0x02 held stable with rsp_valid=1 throughout, C=1; returns to IDLE one edge after rsp_ready=1.
5. Illegal op and external P load:
   - cmd_op=0x00 -> illegal_op pulses 1 cycle, registers unchanged, next command accepted immediately.
   - p_wr_en with p_wr_data=0x00 in IDLE -> P=0x20 (bit5 forced).
6. Reset mid-operation: assert rst_n=0 during WB of ADC dst A -> A keeps its reset value 0, P=0x24; a subsequent command completes normally.
